// File: rtl/operand_select_buf_if.sv
// Operand selector bus: request side (register file / decoder) and
// operand side (ALU) bundled together. The slave modport is the buffer.
interface operand_select_buf_if #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
);
    logic [NUM_SRC*IN_W-1:0] src_data;
    logic [SEL_W-1:0]        src_sel;
    logic                    sign_ext;
    logic                    zero_op;
    logic                    req_valid;
    logic                    req_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_err;

    modport slave (
        input  src_data,
        input  src_sel,
        input  sign_ext,
        input  zero_op,
        input  req_valid,
        output req_ready,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_err
    );

    modport master (
        output src_data,
        output src_sel,
        output sign_ext,
        output zero_op,
        output req_valid,
        input  req_ready,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_err
    );
endinterface

// File: rtl/operand_select_buf.sv
// ALU operand selector with a 2-entry output buffer.
// Picks one of NUM_SRC sources, zero/sign-extends IN_W -> OUT_W, and queues
// {data, err} so a stalled ALU can back-pressure operand fetch.
//
// state | meaning
// ------+-------------------------------------------
// EMPTY | no entries queued, out_valid low
// ONE   | entry 0 is the head, entry 1 unused
// FULL  | entry 0 is the head, entry 1 queued behind it; req_ready low
module operand_select_buf #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_select_buf_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [OUT_W-1:0]  ent0_data;
    logic              ent0_err;
    logic [OUT_W-1:0]  ent1_data;
    logic              ent1_err;
    logic [OUT_W-1:0]  ent0_data_nxt;
    logic              ent0_err_nxt;
    logic [OUT_W-1:0]  ent1_data_nxt;
    logic              ent1_err_nxt;

    logic [IN_W-1:0]   src_val;
    logic              sel_in_range;
    logic [OUT_W-1:0]  new_data;
    logic              new_err;

    logic              push;
    logic              pop;
    logic              req_ready_int;
    logic              out_valid_int;

    // Handshake flags depend only on registered state, so there is no
    // combinational path from out_ready to req_ready or from req_* to out_*.
    assign req_ready_int = (state != FULL);
    assign out_valid_int = (state != EMPTY);

    assign push = bus.req_valid && req_ready_int;
    assign pop  = out_valid_int && bus.out_ready;

    assign bus.req_ready = req_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = out_valid_int ? ent0_data : '0;
    assign bus.out_err   = out_valid_int ? ent0_err  : 1'b0;

    // Source mux: the loop only visits legal indices, so an out-of-range
    // select never reads past the packed source vector.
    always_comb begin
        src_val      = '0;
        sel_in_range = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.src_sel == SEL_W'(k)) begin
                src_val      = bus.src_data[k*IN_W +: IN_W];
                sel_in_range = 1'b1;
            end
        end
    end

    // Operand formation: zero_op beats a bad select, which beats extension.
    // The signed size cast replicates the MSB and degenerates to a plain
    // copy when OUT_W == IN_W.
    always_comb begin
        new_data = '0;
        new_err  = 1'b0;
        if (bus.zero_op) begin
            new_data = '0;
            new_err  = 1'b0;
        end else if (!sel_in_range) begin
            new_data = '0;
            new_err  = 1'b1;
        end else if (bus.sign_ext) begin
            new_data = OUT_W'(signed'(src_val));
        end else begin
            new_data = OUT_W'(src_val);
        end
    end

    // Buffer occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and entry contents; entry 0 is always the head, and
    // entry 1 shifts down on a pop from FULL.
    always_comb begin
        state_nxt     = state;
        ent0_data_nxt = ent0_data;
        ent0_err_nxt  = ent0_err;
        ent1_data_nxt = ent1_data;
        ent1_err_nxt  = ent1_err;
        case (state)
            EMPTY: begin
                if (push) begin
                    ent0_data_nxt = new_data;
                    ent0_err_nxt  = new_err;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b11: begin
                        ent0_data_nxt = new_data;
                        ent0_err_nxt  = new_err;
                    end
                    2'b10: begin
                        ent1_data_nxt = new_data;
                        ent1_err_nxt  = new_err;
                        state_nxt     = FULL;
                    end
                    2'b01: begin
                        state_nxt = EMPTY;
                    end
                    default: begin
                        state_nxt = ONE;
                    end
                endcase
            end
            FULL: begin
                if (pop) begin
                    ent0_data_nxt = ent1_data;
                    ent0_err_nxt  = ent1_err;
                    state_nxt     = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Entry storage; reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_data <= '0;
            ent0_err  <= 1'b0;
            ent1_data <= '0;
            ent1_err  <= 1'b0;
        end else begin
            ent0_data <= ent0_data_nxt;
            ent0_err  <= ent0_err_nxt;
            ent1_data <= ent1_data_nxt;
            ent1_err  <= ent1_err_nxt;
        end
    end

endmodule

// File: tb/tb_operand_select_buf.sv
// Directed bench for operand_select_buf with three 4-bit sources
// (sel 3 is out of range) extended to 8 bits.
module tb_operand_select_buf;

    localparam int IN_W    = 4;
    localparam int OUT_W   = 8;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    operand_select_buf_if #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)
    ) bus ();

    operand_select_buf #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] sel, input logic sx, input logic zo);
        bus.req_valid = v;
        bus.src_sel   = sel;
        bus.sign_ext  = sx;
        bus.zero_op   = zo;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] d, input logic e);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, bus.out_data},  {24'd0, d});
        chk({tag, "_err"},   {31'd0, bus.out_err},   {31'd0, e});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, bus.out_data},  32'd0);
        chk({tag, "_err"},   {31'd0, bus.out_err},   32'd0);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Accept one request into an empty buffer, check it, then pop it.
    task automatic single(input string tag, input logic [1:0] sel, input logic sx,
                          input logic zo, input logic [7:0] d, input logic e);
        set_req(1'b1, sel, sx, zo);
        step();
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        chk_head(tag, d, e);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_popped"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.src_data  = {4'h5, 4'h3, 4'hA};
        bus.out_ready = 1'b0;
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        #12;
        chk_empty("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_empty("idle");

        // Capture at accept: changing the source afterwards must not matter.
        set_req(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        bus.src_data = {4'h5, 4'h3, 4'hC};
        chk_head("zext_sel0", 8'h0A, 1'b0);
        step();
        chk_head("held_sel0", 8'h0A, 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pop_sel0", {31'd0, bus.out_valid}, 32'd0);
        bus.src_data = {4'h5, 4'h3, 4'hA};

        single("sext_sel0", 2'd0, 1'b1, 1'b0, 8'hFA, 1'b0);
        single("sext_sel1", 2'd1, 1'b1, 1'b0, 8'h03, 1'b0);
        single("zext_sel2", 2'd2, 1'b0, 1'b0, 8'h05, 1'b0);
        single("bad_sel3",  2'd3, 1'b0, 1'b0, 8'h00, 1'b1);
        single("zero_sel3", 2'd3, 1'b1, 1'b1, 8'h00, 1'b0);
        single("zero_sel0", 2'd0, 1'b1, 1'b1, 8'h00, 1'b0);

        // Back-pressure: three requests with the ALU stalled.
        set_req(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        chk("bp_ready1", {31'd0, bus.req_ready}, 32'd1);
        set_req(1'b1, 2'd0, 1'b1, 1'b0);
        step();
        chk("bp_ready2", {31'd0, bus.req_ready}, 32'd0);
        set_req(1'b1, 2'd1, 1'b0, 1'b0);
        step();
        chk("bp_ready3", {31'd0, bus.req_ready}, 32'd0);
        chk_head("bp_stall", 8'h0A, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk_head("bp_second", 8'hFA, 1'b0);
        chk("bp_ready4", {31'd0, bus.req_ready}, 32'd1);
        step();
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        chk_head("bp_third", 8'h03, 1'b0);
        step();
        bus.out_ready = 1'b0;
        chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Count held at 1 by a push and pop every cycle.
        set_req(1'b1, 2'd2, 1'b0, 1'b0);
        step();
        chk_head("pp_first", 8'h05, 1'b0);
        bus.out_ready = 1'b1;
        set_req(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        chk_head("pp_c1", 8'h0A, 1'b0);
        chk("pp_ready1", {31'd0, bus.req_ready}, 32'd1);
        set_req(1'b1, 2'd0, 1'b1, 1'b0);
        step();
        chk_head("pp_c2", 8'hFA, 1'b0);
        set_req(1'b1, 2'd3, 1'b0, 1'b0);
        step();
        chk_head("pp_c3", 8'h00, 1'b1);
        chk("pp_ready3", {31'd0, bus.req_ready}, 32'd1);
        set_req(1'b1, 2'd1, 1'b1, 1'b0);
        step();
        chk_head("pp_c4", 8'h03, 1'b0);
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        chk("pp_drained", {31'd0, bus.out_valid}, 32'd0);

        // Asynchronous reset with two entries queued.
        set_req(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        set_req(1'b1, 2'd0, 1'b1, 1'b0);
        step();
        set_req(1'b0, 2'd0, 1'b0, 1'b0);
        chk("rst_full", {31'd0, bus.req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("rst_async");
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk_empty("rst_after1");
        step();
        chk_empty("rst_after2");
        bus.out_ready = 1'b0;
        single("rst_reuse", 2'd1, 1'b0, 1'b0, 8'h03, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
